// File: rtl/rsa_pkg.sv
// Shared definitions for the modular exponentiation controller.
//   N      : operand / modulus width (Montgomery R = 2^N)
//   LEN_W  : width of the exponent-length field (holds 0..N)
//   state_e: controller operation state
//   phase_e: per-operation sub-phase (ISSUE a multiplier job, WAIT for it)
package rsa_pkg;

  localparam int N     = 512;
  localparam int LEN_W = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SQR,
    S_MUL,
    S_POST,
    S_DONE
  } state_e;

  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_e;

endpackage

// File: rtl/montgomery_exp.sv
// Left-to-right square-and-multiply exponentiation, result = x^e mod M,
// driving an external Montgomery multiplier over a start/done handshake.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands latched when start is seen
// PRE   | job (x, R^2 mod M) -> xt; accumulator loaded with R mod M
// SQR   | job (A, A) -> A; exponent index decremented
// MUL   | job (A, xt) -> A; taken when the freshly indexed exponent bit is 1
// POST  | job (A, 1) -> result (leaves the Montgomery domain)
// DONE  | one-cycle done pulse, then back to IDLE
// Every operation state runs ISSUE (one mm_start pulse) then WAIT (mm_done).
//
// Ports:
//   clk, resetn                 clock, async active-low reset
//   start                       one-cycle request, operands sampled same cycle
//   in_x, in_e, in_e_len        base, exponent, significant exponent bits
//   in_m, in_rmodm, in_r2modm   odd modulus, R mod M, R^2 mod M
//   result, done, busy          answer (valid with done), pulse, activity
//   mm_start, mm_a, mm_b, mm_m  multiplier job request and operands
//   mm_result, mm_done          multiplier answer and completion pulse
module montgomery_exp #(
  parameter int N     = rsa_pkg::N,
  parameter int LEN_W = rsa_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [N-1:0]     in_x,
  input  logic [N-1:0]     in_e,
  input  logic [LEN_W-1:0] in_e_len,
  input  logic [N-1:0]     in_m,
  input  logic [N-1:0]     in_rmodm,
  input  logic [N-1:0]     in_r2modm,
  output logic [N-1:0]     result,
  output logic             done,
  output logic             busy,
  output logic             mm_start,
  output logic [N-1:0]     mm_a,
  output logic [N-1:0]     mm_b,
  output logic [N-1:0]     mm_m,
  input  logic [N-1:0]     mm_result,
  input  logic             mm_done
);
  import rsa_pkg::*;

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;

  logic [N-1:0]     x_q, e_q, m_q, rm_q, r2_q;
  logic [N-1:0]     xt_q, acc_q, result_q;
  logic [LEN_W-1:0] i_q;
  logic [LEN_W-1:0] i_dec;
  logic [LEN_W-1:0] len_clamped;
  logic [N-1:0]     e_shift;
  logic             e_bit_dec;
  logic             job_done;

  assign i_dec       = i_q - LEN_W'(1);
  // Exponent bit at the index after this square's decrement decides MUL.
  assign e_shift     = e_q >> i_dec;
  assign e_bit_dec   = e_shift[0];
  assign len_clamped = (in_e_len > LEN_W'(N)) ? LEN_W'(N) : in_e_len;
  // Phase is only WAIT inside an operation state, so mm_done elsewhere is dropped.
  assign job_done    = (phase_q == PH_WAIT) && mm_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      phase_q <= PH_ISSUE;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      S_IDLE: begin
        phase_d = PH_ISSUE;
        if (start) state_d = S_PRE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        phase_d = PH_ISSUE;
      end
      default: begin
        if (phase_q == PH_ISSUE) begin
          phase_d = PH_WAIT;
        end else if (mm_done) begin
          phase_d = PH_ISSUE;
          case (state_q)
            S_PRE:   state_d = (i_q != '0) ? S_SQR : S_POST;
            S_SQR: begin
              if (e_bit_dec)          state_d = S_MUL;
              else if (i_dec != '0)   state_d = S_SQR;
              else                    state_d = S_POST;
            end
            S_MUL:   state_d = (i_q != '0) ? S_SQR : S_POST;
            S_POST:  state_d = S_DONE;
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q      <= '0;
      e_q      <= '0;
      m_q      <= '0;
      rm_q     <= '0;
      r2_q     <= '0;
      xt_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      i_q      <= '0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        x_q   <= in_x;
        e_q   <= in_e;
        m_q   <= in_m;
        rm_q  <= in_rmodm;
        r2_q  <= in_r2modm;
        acc_q <= '0;
        i_q   <= len_clamped;
      end
      if (job_done) begin
        case (state_q)
          S_PRE: begin
            xt_q  <= mm_result;
            acc_q <= rm_q;
          end
          S_SQR: begin
            acc_q <= mm_result;
            i_q   <= i_dec;
          end
          S_MUL:   acc_q    <= mm_result;
          S_POST:  result_q <= mm_result;
          default: ;
        endcase
      end
    end
  end

  // Operands are decoded from registers that only change on the capture
  // edge, so they stay put for the whole ISSUE..mm_done window.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    mm_start = 1'b0;
    mm_a     = '0;
    mm_b     = '0;
    case (state_q)
      S_PRE: begin
        busy = 1'b1;
        mm_a = x_q;
        mm_b = r2_q;
      end
      S_SQR: begin
        busy = 1'b1;
        mm_a = acc_q;
        mm_b = acc_q;
      end
      S_MUL: begin
        busy = 1'b1;
        mm_a = acc_q;
        mm_b = xt_q;
      end
      S_POST: begin
        busy = 1'b1;
        mm_a = acc_q;
        mm_b = N'(1);
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
    if (busy && (phase_q == PH_ISSUE)) mm_start = 1'b1;
  end

  assign mm_m   = m_q;
  assign result = result_q;

endmodule

// File: tb/tb_montgomery_exp.sv
// Bench for montgomery_exp at N=8, M=187 (R mod M = 69, R^2 mod M = 86),
// with a fixed-latency (L=3) behavioural Montgomery multiplier.
module tb_montgomery_exp;

  localparam int         N     = 8;
  localparam int         LEN_W = 10;
  localparam int         L     = 3;
  localparam logic [7:0] M     = 8'd187;
  localparam logic [7:0] RM    = 8'd69;
  localparam logic [7:0] R2    = 8'd86;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [N-1:0]     in_x = '0, in_e = '0, in_m = '0, in_rmodm = '0, in_r2modm = '0;
  logic [LEN_W-1:0] in_e_len = '0;
  logic [N-1:0]     result, mm_a, mm_b, mm_m;
  logic [N-1:0]     mm_result = '0;
  logic             done, busy, mm_start, mm_done;
  logic             mm_done_q = 1'b0;
  logic             spur_done = 1'b0;

  always #5 clk = ~clk;

  assign mm_done = mm_done_q | spur_done;

  montgomery_exp #(.N(N), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .in_x      (in_x),
    .in_e      (in_e),
    .in_e_len  (in_e_len),
    .in_m      (in_m),
    .in_rmodm  (in_rmodm),
    .in_r2modm (in_r2modm),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .mm_start  (mm_start),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_m      (mm_m),
    .mm_result (mm_result),
    .mm_done   (mm_done)
  );

  // a * b * 2^-8 mod 187, fully reduced
  function automatic logic [7:0] mont(input logic [7:0] a, input logic [7:0] b);
    logic [17:0] t;
    t = 18'(a) * 18'(b);
    for (int k = 0; k < N; k++) begin
      if (t[0]) t = t + 18'(M);
      t = t >> 1;
    end
    if (t >= 18'(M)) t = t - 18'(M);
    return t[7:0];
  endfunction

  // Plain x^e mod M over the low len exponent bits, no Montgomery arithmetic.
  function automatic logic [7:0] modexp(input logic [7:0] x, input logic [7:0] e, input int len);
    int r, b;
    logic [7:0] es;
    r = 1;
    b = int'(x);
    for (int i = 0; i < len; i++) begin
      es = e >> i;
      if (es[0]) r = (r * b) % int'(M);
      b = (b * b) % int'(M);
    end
    return 8'(r);
  endfunction

  // Behavioural multiplier: records each job, answers L cycles after mm_start,
  // and counts operand changes seen while a job is outstanding.
  logic [15:0] obs_jobs[$];
  logic [7:0]  lat_a = '0, lat_b = '0;
  logic        pend_q = 1'b0;
  int          cnt_q = 0;
  int          unstable_cnt = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_q    <= 1'b0;
      mm_done_q <= 1'b0;
      cnt_q     <= 0;
    end else begin
      mm_done_q <= 1'b0;
      if ((pend_q || mm_done_q) && ({mm_a, mm_b} !== {lat_a, lat_b}))
        unstable_cnt <= unstable_cnt + 1;
      if (mm_start) begin
        obs_jobs.push_back({mm_a, mm_b});
        lat_a  <= mm_a;
        lat_b  <= mm_b;
        pend_q <= 1'b1;
        cnt_q  <= L - 1;
      end else if (pend_q) begin
        if (cnt_q == 1) begin
          mm_done_q <= 1'b1;
          mm_result <= mont(lat_a, lat_b);
          pend_q    <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 1;
        end
      end
    end
  end

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Cycles are numbered from 1 in the cycle where start is high.
  task automatic run_case(input string tag, input logic [7:0] x, input logic [7:0] e,
                          input logic [LEN_W-1:0] elen, input bit repulse);
    logic [15:0] ej[$];
    logic [7:0]  xt, acc, es, r;
    int          len, base, cnt, nobs;
    bit          got;
    len = (elen > LEN_W'(N)) ? N : int'(elen);
    xt  = mont(x, R2);
    acc = RM;
    ej.push_back({x, R2});
    for (int i = len - 1; i >= 0; i--) begin
      ej.push_back({acc, acc});
      acc = mont(acc, acc);
      es  = e >> i;
      if (es[0]) begin
        ej.push_back({acc, xt});
        acc = mont(acc, xt);
      end
    end
    ej.push_back({acc, 8'd1});
    exp_q.push_back(modexp(x, e, len));
    base = obs_jobs.size();

    @(negedge clk);
    in_x = x; in_e = e; in_e_len = elen;
    in_m = M; in_rmodm = RM; in_r2modm = R2;
    start = 1'b1;
    cnt = 1;
    got = 1'b0;
    while (cnt < 400 && !got) begin
      @(negedge clk);
      cnt++;
      start = repulse && (cnt == 12);
      if (start) in_x = 8'd7;
      got = done;
    end
    start = 1'b0;

    chk($sformatf("%s done_seen", tag), 32'(got), 32'(1));
    chk($sformatf("%s latency", tag), 32'(cnt), 32'(ej.size() * (L + 1) + 2));
    r = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    chk($sformatf("%s result", tag), 32'(result), 32'(r));
    chk($sformatf("%s busy_at_done", tag), 32'(busy), 32'(0));
    nobs = obs_jobs.size() - base;
    chk($sformatf("%s job_count", tag), 32'(nobs), 32'(ej.size()));
    for (int k = 0; k < ej.size() && k < nobs; k++)
      chk($sformatf("%s job%0d_ab", tag, k), 32'(obs_jobs[base + k]), 32'(ej[k]));
    chk($sformatf("%s operand_stability", tag), 32'(unstable_cnt), 32'(0));
    chk($sformatf("%s mm_m", tag), 32'(mm_m), 32'(M));
    @(negedge clk);
    chk($sformatf("%s done_one_cycle", tag), 32'(done), 32'(0));
    chk($sformatf("%s result_held", tag), 32'(result), 32'(r));
  endtask

  initial begin
    int base, dcount;

    repeat (2) @(negedge clk);
    chk("reset result", 32'(result), 32'(0));
    chk("reset done", 32'(done), 32'(0));
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset mm_start", 32'(mm_start), 32'(0));
    chk("reset mm_a", 32'(mm_a), 32'(0));
    chk("reset mm_b", 32'(mm_b), 32'(0));
    chk("reset mm_m", 32'(mm_m), 32'(0));
    resetn = 1'b1;
    @(negedge clk);

    run_case("x2e7",    8'd2, 8'h07, 10'd3,  1'b0);
    run_case("x3e5",    8'd3, 8'h05, 10'd3,  1'b0);
    run_case("elen0",   8'd5, 8'hFF, 10'd0,  1'b0);
    run_case("upper",   8'd3, 8'hF5, 10'd3,  1'b0);
    run_case("clamp",   8'd2, 8'h07, 10'd12, 1'b0);
    run_case("repulse", 8'd3, 8'h05, 10'd3,  1'b1);

    // Stray multiplier completion while idle.
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    chk("spur busy", 32'(busy), 32'(0));
    chk("spur done", 32'(done), 32'(0));
    chk("spur mm_start", 32'(mm_start), 32'(0));
    @(negedge clk);
    chk("spur busy_later", 32'(busy), 32'(0));
    chk("spur result", 32'(result), 32'(56));
    run_case("after_spur", 8'd2, 8'h07, 10'd3, 1'b0);

    // Reset during the first square's WAIT (cycles 7..9 of this run).
    base = obs_jobs.size();
    @(negedge clk);
    in_x = 8'd3; in_e = 8'h05; in_e_len = 10'd3;
    in_m = M; in_rmodm = RM; in_r2modm = R2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort jobs_before_reset", 32'(obs_jobs.size() - base), 32'(2));
    chk("abort busy_before_reset", 32'(busy), 32'(1));
    resetn = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'(0));
    chk("abort mm_start", 32'(mm_start), 32'(0));
    chk("abort done", 32'(done), 32'(0));
    chk("abort mm_a", 32'(mm_a), 32'(0));
    chk("abort result", 32'(result), 32'(0));
    dcount = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) resetn = 1'b1;
      if (done) dcount++;
    end
    chk("abort no_done", 32'(dcount), 32'(0));
    chk("abort idle_after", 32'(busy), 32'(0));
    run_case("post_reset", 8'd3, 8'h05, 10'd3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
